seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//  Serial pattern transmitter: source side of the serial sequence-detector link.
//  Loads a PAT_W-bit pattern and shifts it out MSB first, one bit per clk, repeated reps times.
//  Inserts GAP idle cycles between repetitions. Drives the x input of the downstream Mealy detectors.
// PARAMETERS
//  PAT_W  default 4  pattern width in bits (>=2)
//  CNT_W  default 4  width of repetition count
//  GAP    default 0  idle cycles between repetitions (0 = back-to-back)
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request transmission; sampled only in IDLE
//  abort    in   1      terminate an active transmission
//  pattern  in   PAT_W  pattern to send, captured on accepted start
//  reps     in   CNT_W  repetition count, captured on accepted start
//  x        out  1      serial data bit
//  x_vld    out  1      x carries a pattern (or parity) bit this cycle
//  busy     out  1      transmission in progress
//  done     out  1      one-cycle pulse after last bit of last repetition
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, shift register and counters cleared.
//  States: IDLE, SHIFT, GAP (PARITY when compiled in).
//  IDLE: start=1 at edge t -> capture pattern/reps; busy=1, x=pattern[MSB], x_vld=1 from t+1.
//  reps==0 on start: no bits sent; done=1 at t+1 for one cycle, busy stays 0.
//  SHIFT: PAT_W cycles, MSB first; bit counter counts PAT_W-1 downto 0.
//  End of repetition: rep counter decrements; if reps remain -> GAP (GAP>0) else reload, SHIFT.
//  Reload from captured copy; pattern input changes during busy are ignored.
//  GAP: exactly GAP cycles, x=0, x_vld=0, busy=1, then SHIFT with reloaded pattern.
//  Last repetition complete -> IDLE; done=1 and busy=0 in the first IDLE cycle.
//  start while busy: ignored, no queueing. start and done same cycle: start accepted.
//  abort=1 in SHIFT/GAP: next edge -> IDLE, x=0, x_vld=0, busy=0, no done pulse.
//  abort in IDLE: no effect. abort and start same IDLE cycle: abort wins, start dropped.
//  rst mid-transmission: same as reset; no done pulse, captured pattern discarded.
//  x=0 whenever x_vld=0. Outputs are registered; no combinational path from inputs.
//  Counter wrap: rep counter never decrements below 0; CNT_W max value 2**CNT_W-1 honoured.
// CONFIGURATION
//  SEQ_TX_PARITY_EN defined: after each repetition's PAT_W bits, one PARITY cycle
//   sends even parity (^pattern) with x_vld=1; repetition length = PAT_W+1 cycles.
//   abort during PARITY behaves as in SHIFT.
//  Not defined: no PARITY state; repetition length = PAT_W cycles.
// STRUCTURE
//  Package seq_pkg: state enum (IDLE, SHIFT, GAP, PARITY), state width constant,
//   shared with the detector blocks for the common pattern width default.
//  Sub-module seq_tx_shreg: PAT_W-bit load/shift register with MSB tap;
//   parent holds FSM, bit counter, rep counter, gap counter.
// TESTING
//  PAT_W=4, GAP=0: pattern=4'b1010, reps=3, start -> x=101010101010 over 12 cycles,
//   x_vld=1 throughout, done pulse on cycle 13, a 1010 detector raises y 3 times.
//  GAP=2: pattern=4'b1100, reps=2 -> 1100,00(x_vld=0),1100; done 1 cycle after last bit.
//  reps=0, start -> no x_vld, done=1 next cycle, busy never asserts.
//  abort asserted on 3rd bit of rep 2 of reps=4 -> IDLE next edge, busy=0, no done.
//  start held during busy with new pattern -> ignored; transmitted bits unchanged.
//  SEQ_TX_PARITY_EN: pattern=4'b1011, reps=1 -> x=1011 then parity 1, done after 5 bits.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and defaults for the serial sequence link
// Purpose: state enum for the pattern transmitter FSM and the common pattern width
//          default also used by the downstream detector blocks.
// Ports:   none (package)
package seq_pkg;

  localparam int STATE_W       = 2;
  localparam int PAT_W_DEFAULT = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_GAP    = 2'd2,
    ST_PARITY = 2'd3
  } state_t;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - control and serial-output bundle of the pattern transmitter
// Purpose: groups the request side (start/abort/pattern/reps) and the serial side
//          (x/x_vld/busy/done) of seq_pattern_tx.
// Ports:   master - drives start, abort, pattern, reps; observes x, x_vld, busy, done
//          slave  - the transmitter side of the same signals
interface seq_pattern_tx_if
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = 4
);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             x;
  logic             x_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, reps,
    input  x, x_vld, busy, done
  );

  modport slave (
    input  start, abort, pattern, reps,
    output x, x_vld, busy, done
  );

endinterface

// File: rtl/seq_tx_shreg.sv
// rtl/seq_tx_shreg.sv - load/shift register with MSB tap for the pattern transmitter
// Purpose: holds the pattern being serialised; load has priority over shift,
//          shifting moves the next bit into the MSB position.
// Ports:   clk, rst (sync, active-high)
//          load_i  - load din_i
//          shift_i - shift left by one, zero fill
//          din_i   - PAT_W-bit load value
//          msb_o   - current MSB (the bit on the line)
module seq_tx_shreg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] din_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[PAT_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter driving the sequence-detector x input
// Purpose: captures pattern/reps on an accepted start and shifts the pattern out MSB
//          first, reps times, with GAP idle cycles between repetitions.
//          Optional macro SEQ_TX_PARITY_EN appends one even-parity bit per repetition.
// Ports:   clk, rst (sync, active-high)
//          bus (seq_pattern_tx_if.slave):
//            start, abort, pattern, reps  - request inputs
//            x, x_vld, busy, done         - serial output and status, all from flops
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic            clk,
  input  logic            rst,
  seq_pattern_tx_if.slave bus
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_q, done_d;

  logic             sh_load, sh_shift, sh_msb;
  logic [PAT_W-1:0] sh_din;
  logic             rep_end;

  seq_tx_shreg #(.PAT_W(PAT_W)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .din_i   (sh_din),
    .msb_o   (sh_msb)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rep_d    = rep_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = pat_q;
    rep_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort outranks start; a zero-rep request only produces the done pulse
        if (!bus.abort && bus.start) begin
          if (bus.reps == '0) begin
            done_d = 1'b1;
          end else begin
            pat_d   = bus.pattern;
            rep_d   = bus.reps;
            sh_din  = bus.pattern;
            sh_load = 1'b1;
            bit_d   = BIT_LAST;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bit_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          rep_end = 1'b1;
`endif
        end else begin
          bit_d    = bit_q - BIT_W'(1);
          sh_shift = 1'b1;
        end
      end
      ST_PARITY: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          rep_end = 1'b1;
        end
      end
      ST_GAP: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          sh_load = 1'b1;
          bit_d   = BIT_LAST;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // rep_q counts repetitions still owed including the current one, so it
    // never has to go below 1 before the final return to IDLE
    if (rep_end) begin
      if (rep_q <= CNT_W'(1)) begin
        rep_d   = '0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end else begin
        rep_d = rep_q - CNT_W'(1);
        if (GAP > 0) begin
          gap_d   = GAP_LAST;
          state_d = ST_GAP;
        end else begin
          sh_load = 1'b1;
          bit_d   = BIT_LAST;
          state_d = ST_SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded only from flops; x is forced low outside data cycles
  assign bus.x     = (state_q == ST_SHIFT)  ? sh_msb :
                     (state_q == ST_PARITY) ? ^pat_q : 1'b0;
  assign bus.x_vld = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - scoreboard bench for seq_pattern_tx (GAP=0 and GAP=2 instances)
module tb_seq_pattern_tx;

  localparam int PW    = 4;
  localparam int CW    = 4;
  localparam int GAP_B = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    int   cyc;
    logic b;
  } exp_bit_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  exp_bit_t qa_bits[$];
  exp_bit_t qb_bits[$];
  int       qa_done[$];
  int       qb_done[$];
  exp_bit_t ea, eb;

  seq_pattern_tx_if #(.PAT_W(PW), .CNT_W(CW)) ia ();
  seq_pattern_tx_if #(.PAT_W(PW), .CNT_W(CW)) ib ();

  seq_pattern_tx #(.PAT_W(PW), .CNT_W(CW), .GAP(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  seq_pattern_tx #(.PAT_W(PW), .CNT_W(CW), .GAP(GAP_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for one request accepted at edge t (first bit in cycle t).
  // nbits >= 0 truncates the stream (abort/reset) and suppresses done.
  task automatic model(input bit which, input logic [PW-1:0] pat, input int reps,
                       input int t, input int gap, input int nbits);
    int c = t;
    int n = 0;
    exp_bit_t e;
    for (int r = 0; r < reps; r++) begin
      for (int i = PW - 1; i >= 0; i--) begin
        e.cyc = c; e.b = pat[i];
        if (nbits < 0 || n < nbits) begin
          if (which) qb_bits.push_back(e); else qa_bits.push_back(e);
        end
        n++; c++;
      end
      if (PAR != 0) begin
        e.cyc = c; e.b = ^pat;
        if (nbits < 0 || n < nbits) begin
          if (which) qb_bits.push_back(e); else qa_bits.push_back(e);
        end
        n++; c++;
      end
      if (r < reps - 1) c += gap;
    end
    if (nbits < 0) begin
      if (which) qb_done.push_back(c); else qa_done.push_back(c);
    end
  endtask

  task automatic start_a(input logic [PW-1:0] pat, input int reps, input int nbits);
    model(1'b0, pat, reps, edge_cnt + 1, 0, nbits);
    ia.pattern = pat; ia.reps = CW'(reps); ia.start = 1'b1;
    step();
    ia.start = 1'b0;
  endtask

  task automatic start_b(input logic [PW-1:0] pat, input int reps);
    model(1'b1, pat, reps, edge_cnt + 1, GAP_B, -1);
    ib.pattern = pat; ib.reps = CW'(reps); ib.start = 1'b1;
    step();
    ib.start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((qa_bits.size() + qa_done.size() + qb_bits.size() + qb_done.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    check(name, qa_bits.size() + qa_done.size() + qb_bits.size() + qb_done.size(), 0);
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ia.x_vld === 1'b1) begin
        if (qa_bits.size() == 0) check("a_unexpected_bit", 1, 0);
        else begin
          ea = qa_bits.pop_front();
          check("a_bit_cycle", edge_cnt, ea.cyc);
          check("a_bit_value", int'(ia.x), int'(ea.b));
        end
      end else begin
        check("a_x_when_invalid", int'(ia.x), 0);
      end
      if (ia.done === 1'b1) begin
        if (qa_done.size() == 0) check("a_unexpected_done", 1, 0);
        else check("a_done_cycle", edge_cnt, qa_done.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ib.x_vld === 1'b1) begin
        if (qb_bits.size() == 0) check("b_unexpected_bit", 1, 0);
        else begin
          eb = qb_bits.pop_front();
          check("b_bit_cycle", edge_cnt, eb.cyc);
          check("b_bit_value", int'(ib.x), int'(eb.b));
        end
      end else begin
        check("b_x_when_invalid", int'(ib.x), 0);
      end
      if (ib.done === 1'b1) begin
        if (qb_done.size() == 0) check("b_unexpected_done", 1, 0);
        else check("b_done_cycle", edge_cnt, qb_done.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    ia.start = 1'b0; ia.abort = 1'b0; ia.pattern = '0; ia.reps = '0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.pattern = '0; ib.reps = '0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_a_busy",  int'(ia.busy),  0);
    check("rst_a_x_vld", int'(ia.x_vld), 0);
    check("rst_a_x",     int'(ia.x),     0);
    check("rst_a_done",  int'(ia.done),  0);
    check("rst_b_busy",  int'(ib.busy),  0);
    rst = 1'b0;
    step();
    mon_en = 1'b1;

    // 1010 x3 back-to-back, then a new start in the done cycle
    t = edge_cnt + 1;
    start_a(4'b1010, 3, -1);
    check("a_busy_first_cycle", int'(ia.busy), 1);
    while (edge_cnt < t + 12) step();
    check("a_done_at_13th_cycle", int'(ia.done), 1);
    check("a_busy_low_with_done", int'(ia.busy), 0);
    start_a(4'b0011, 1, -1);
    drain("drain_back_to_back", 100);

    // start held during busy with a different pattern is ignored
    start_a(4'b0110, 2, -1);
    ia.pattern = 4'b1111; ia.reps = 4'd5; ia.start = 1'b1;
    repeat (5) step();
    ia.start = 1'b0;
    drain("drain_start_while_busy", 100);

    // reps=0: done next cycle, busy never asserts
    start_a(4'b1111, 0, -1);
    check("rep0_busy", int'(ia.busy), 0);
    check("rep0_x_vld", int'(ia.x_vld), 0);
    step();
    check("rep0_busy_after", int'(ia.busy), 0);
    drain("drain_rep0", 20);

    // abort and start in the same idle cycle: abort wins
    ia.pattern = 4'b1111; ia.reps = 4'd2; ia.start = 1'b1; ia.abort = 1'b1;
    step();
    ia.start = 1'b0; ia.abort = 1'b0;
    check("abort_start_busy", int'(ia.busy), 0);
    step();
    check("abort_start_busy_later", int'(ia.busy), 0);

    // abort on 3rd bit of rep 2 of reps=4
    start_a(4'b1101, 4, 7);
    repeat (6) step();
    ia.abort = 1'b1;
    step();
    ia.abort = 1'b0;
    check("abort_busy", int'(ia.busy), 0);
    check("abort_x_vld", int'(ia.x_vld), 0);
    drain("drain_abort", 20);

    // maximum repetition count
    start_a(4'b1001, 15, -1);
    drain("drain_max_reps", 200);

    // parity-case pattern (parity bit included only in parity builds)
    start_a(4'b1011, 1, -1);
    drain("drain_1011", 20);

    // reset mid-transmission: six bits out, then nothing, no done
    start_a(4'b0111, 3, 6);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", int'(ia.busy), 0);
    check("midrst_x_vld", int'(ia.x_vld), 0);
    drain("drain_midrst", 20);

    // GAP=2 instance
    t = edge_cnt + 1;
    start_b(4'b1100, 2);
    step(); step(); step(); step();
    check("b_gap_busy", int'(ib.busy), 1);
    check("b_gap_x_vld", int'(ib.x_vld), 0);
    drain("drain_gap_1100", 50);
    start_b(4'b1001, 3);
    drain("drain_gap_1001", 60);

    check("final_queues_a", qa_bits.size() + qa_done.size(), 0);
    check("final_queues_b", qb_bits.size() + qb_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
